// File: rtl/spi_frame_writer_if.sv
// SPI bus between an external master and the frame writer.
interface spi_frame_writer_if;
    logic spi_sclk;
    logic spi_ss_n;
    logic spi_mosi;
    logic spi_miso;

    modport master (output spi_sclk, output spi_ss_n, output spi_mosi, input spi_miso);
    modport slave  (input spi_sclk, input spi_ss_n, input spi_mosi, output spi_miso);
endinterface

// File: rtl/spi_frame_writer.sv
// SPI-slave text-frame writer: oversampled SPI byte receiver, burst packet parser,
// staging buffer with atomic commit into a COLS x ROWS frame buffer, registered read port.
module spi_frame_writer #(
    parameter int COLS        = 40,
    parameter int ROWS        = 15,
    parameter int MAX_BURST   = 16,
    parameter bit CPOL        = 1'b0,
    parameter bit CPHA        = 1'b0,
    parameter int SYNC_STAGES = 2
) (
    input  logic                     master_clk,
    input  logic                     reset_n,
    spi_frame_writer_if.slave        spi,
    input  logic [7:0]               rd_col,
    input  logic [7:0]               rd_row,
    output logic [7:0]               rd_char,
    output logic                     byte_valid,
    output logic                     pkt_ok,
    output logic                     pkt_err,
    output logic [7:0]               err_count,
    output logic                     busy
);
    localparam int DEPTH = COLS * ROWS;
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int SW    = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [7:0] COLS_B  = 8'(COLS);
    localparam logic [7:0] ROWS_B  = 8'(ROWS);
    localparam logic [7:0] BURST_B = 8'(MAX_BURST);
    localparam bit SAMPLE_RISE = (CPOL == CPHA);

    typedef enum logic [2:0] {S_IDLE, S_COL, S_ROW, S_LEN, S_DATA, S_END, S_COMMIT} state_t;

    logic [SYNC_STAGES-1:0] sclk_sync, ss_sync, mosi_sync;
    logic sclk_q, ss_q, sclk_s, ss_s, mosi_s;
    logic sample_edge, shift_edge, ss_fall, ss_rise, shift_in, done, abort;

    always_ff @(posedge master_clk) begin
        if (!reset_n) begin
            sclk_sync <= {SYNC_STAGES{CPOL}};
            ss_sync   <= '1;
            mosi_sync <= '0;
            sclk_q    <= CPOL;
            ss_q      <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi.spi_sclk};
            ss_sync   <= {ss_sync[SYNC_STAGES-2:0], spi.spi_ss_n};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi.spi_mosi};
            sclk_q    <= sclk_s;
            ss_q      <= ss_s;
        end
    end

    assign sclk_s      = sclk_sync[SYNC_STAGES-1];
    assign ss_s        = ss_sync[SYNC_STAGES-1];
    assign mosi_s      = mosi_sync[SYNC_STAGES-1];
    assign sample_edge = SAMPLE_RISE ? (sclk_s & ~sclk_q) : (~sclk_s & sclk_q);
    assign shift_edge  = SAMPLE_RISE ? (~sclk_s & sclk_q) : (sclk_s & ~sclk_q);
    assign ss_fall     = ss_q & ~ss_s;
    assign ss_rise     = ~ss_q & ss_s;

    logic [2:0] bit_cnt;
    logic [6:0] shreg;
    logic [7:0] rx_byte, echo_sh;
    logic       miso_r;

    assign shift_in = ~ss_s & sample_edge & ~ss_fall;
    assign done     = shift_in & (bit_cnt == 3'd7);
    assign abort    = ss_rise & (bit_cnt != 3'd0);

    always_ff @(posedge master_clk) begin
        if (!reset_n) begin
            bit_cnt    <= '0;
            shreg      <= '0;
            rx_byte    <= '0;
            byte_valid <= 1'b0;
            echo_sh    <= '0;
            miso_r     <= 1'b0;
        end else begin
            byte_valid <= done;
            if (ss_fall || abort) begin
                bit_cnt <= '0;
            end else if (shift_in) begin
                shreg   <= {shreg[5:0], mosi_s};
                bit_cnt <= bit_cnt + 3'd1;
            end
            if (done) rx_byte <= {shreg, mosi_s};
            // With CPHA=1 the first shift edge presents bit 7 again, so ss_n fall must not consume it
            if (done) begin
                echo_sh <= {shreg, mosi_s};
            end else if (ss_fall) begin
                miso_r <= echo_sh[7];
                if (!CPHA) echo_sh <= {echo_sh[6:0], 1'b0};
            end else if (~ss_s && shift_edge) begin
                miso_r  <= echo_sh[7];
                echo_sh <= {echo_sh[6:0], 1'b0};
            end
            if (ss_s) miso_r <= 1'b0;
        end
    end

    assign spi.spi_miso = miso_r;

    state_t     st, nxt;
    logic [7:0] col_r, row_r;
    logic [4:0] len_r, idx;
    logic       parse_err, wr_last, err_now;
    logic [7:0] stg [MAX_BURST];
    logic [7:0] fb  [DEPTH];
    logic [AW-1:0] waddr, raddr;

    always_ff @(posedge master_clk) begin
        if (!reset_n) st <= S_IDLE;
        else          st <= nxt;
    end

    always_comb begin
        nxt = st;
        if (abort && st != S_COMMIT) begin
            nxt = S_IDLE;
        end else if (st == S_COMMIT) begin
            if (wr_last) nxt = S_IDLE;
        end else if (byte_valid) begin
            case (st)
                S_IDLE: if (rx_byte == 8'hFF) nxt = S_COL;
                S_COL:  nxt = (rx_byte < COLS_B) ? S_ROW : S_IDLE;
                S_ROW:  nxt = (rx_byte < ROWS_B) ? S_LEN : S_IDLE;
                S_LEN:  nxt = (rx_byte != 8'd0 && rx_byte <= BURST_B) ? S_DATA : S_IDLE;
                S_DATA: if (idx + 5'd1 == len_r) nxt = S_END;
                S_END:  nxt = (rx_byte == 8'hFE) ? S_COMMIT : S_IDLE;
                default: nxt = S_IDLE;
            endcase
        end
    end

    always_comb begin
        busy      = (st == S_COMMIT);
        wr_last   = busy && (idx == len_r - 5'd1);
        parse_err = 1'b0;
        if (byte_valid) begin
            case (st)
                S_COL:    parse_err = (rx_byte >= COLS_B);
                S_ROW:    parse_err = (rx_byte >= ROWS_B);
                S_LEN:    parse_err = (rx_byte == 8'd0) || (rx_byte > BURST_B);
                S_END:    parse_err = (rx_byte != 8'hFE);
                S_COMMIT: parse_err = 1'b1;
                default:  parse_err = 1'b0;
            endcase
        end
        err_now = parse_err | abort;
    end

    always_ff @(posedge master_clk) begin
        if (!reset_n) begin
            col_r     <= '0;
            row_r     <= '0;
            len_r     <= '0;
            idx       <= '0;
            pkt_ok    <= 1'b0;
            pkt_err   <= 1'b0;
            err_count <= '0;
        end else begin
            pkt_ok  <= wr_last;
            pkt_err <= err_now;
            if (err_now && err_count != 8'hFF) err_count <= err_count + 8'd1;
            if (busy) begin
                idx <= idx + 5'd1;
                if (col_r == COLS_B - 8'd1) begin
                    col_r <= '0;
                    row_r <= (row_r == ROWS_B - 8'd1) ? 8'd0 : row_r + 8'd1;
                end else begin
                    col_r <= col_r + 8'd1;
                end
            end else if (byte_valid) begin
                case (st)
                    S_COL:  col_r <= rx_byte;
                    S_ROW:  row_r <= rx_byte;
                    S_LEN:  begin len_r <= rx_byte[4:0]; idx <= '0; end
                    S_DATA: idx <= idx + 5'd1;
                    S_END:  idx <= '0;
                    default: ;
                endcase
            end
        end
    end

    assign waddr = AW'({24'd0, row_r} * COLS + {24'd0, col_r});
    assign raddr = AW'({24'd0, rd_row} * COLS + {24'd0, rd_col});

    // Storage arrays carry no reset so they map onto RAM
    always_ff @(posedge master_clk) begin
        if (reset_n && byte_valid && st == S_DATA && !abort) stg[SW'(idx)] <= rx_byte;
    end

    always_ff @(posedge master_clk) begin
        if (reset_n && busy) fb[waddr] <= stg[SW'(idx)];
    end

    always_ff @(posedge master_clk) begin
        if (!reset_n)                                rd_char <= '0;
        else if (rd_col < COLS_B && rd_row < ROWS_B) rd_char <= fb[raddr];
        else                                         rd_char <= '0;
    end
endmodule
